// File: rtl/urv_dmem_bridge_pkg.sv
// Shared definitions for the uRV data-memory bridge: FSM states and
// Wishbone constants.
package urv_dmem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } dmem_state_e;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/urv_dmem_bridge_timeout.sv
// Bus-cycle watchdog for the data-memory bridge: loadable down-counter that
// flags expiry on the g_timeout-th enabled cycle after a clear.
module urv_dmem_timeout #(
  parameter int unsigned g_timeout = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  if (g_timeout == 0) begin : g_off
    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_n_i, clear_i, enable_i};
    assign expired_o = 1'b0;
  end else begin : g_on
    localparam int unsigned W = $clog2(g_timeout + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = W'(g_timeout);
      end else if (enable_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Loaded with g_timeout on the first busy cycle, so the last allowed cycle sees 1.
    assign expired_o = enable_i && (cnt_q == W'(1));
  end

endmodule

// File: rtl/urv_dmem_bridge.sv
// uRV data-memory responder: one load/store per request, run as a single
// pipelined Wishbone cycle with registered done/error strobes.
module urv_dmem_bridge #(
  parameter int unsigned g_timeout  = 255,
  parameter logic [31:0] g_err_data = '0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_error_o,
  output logic [31:0] dm_error_addr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);
  import urv_dmem_bridge_pkg::*;

  dmem_state_e state_q, state_d;
  logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, dat_q, dat_d;
  logic [31:0] data_l_q, data_l_d, err_addr_q, err_addr_d;
  logic [3:0]  sel_q, sel_d;
  logic        load_done_q, load_done_d, store_done_q, store_done_d;
  logic        error_q, error_d;
  logic        tmo_clear, tmo_en, tmo_expired;
  logic        term, failed;

  urv_dmem_timeout #(.g_timeout(g_timeout)) u_timeout (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_en),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    addr_d       = addr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    data_l_d     = data_l_q;
    err_addr_d   = err_addr_q;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    error_d      = 1'b0;
    tmo_clear    = 1'b0;
    tmo_en       = 1'b0;
    term         = 1'b0;
    failed       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (dm_load_i || dm_store_i) begin
          state_d   = ST_REQ;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          we_d      = dm_store_i;
          addr_d    = dm_addr_i;
          dat_d     = dm_data_s_i;
          sel_d     = dm_store_i ? dm_data_select_i : WB_SEL_ALL;
          tmo_clear = 1'b1;
        end
      end
      ST_REQ: begin
        tmo_en = 1'b1;
        if (!wb_stall_i) begin
          stb_d = 1'b0;
          // A terminate in the acceptance cycle completes the access directly.
          if (wb_ack_i || wb_err_i) begin
            term   = 1'b1;
            failed = wb_err_i;
          end else begin
            state_d = ST_WAIT;
          end
        end
        if (!term && tmo_expired) begin
          term   = 1'b1;
          failed = 1'b1;
        end
      end
      ST_WAIT: begin
        tmo_en = 1'b1;
        if (wb_ack_i || wb_err_i) begin
          term   = 1'b1;
          failed = wb_err_i;
        end else if (tmo_expired) begin
          term   = 1'b1;
          failed = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (term) begin
      state_d = ST_IDLE;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      error_d = failed;
      if (we_q) begin
        store_done_d = 1'b1;
      end else begin
        load_done_d = 1'b1;
        data_l_d    = failed ? g_err_data : wb_dat_i;
      end
      if (failed) begin
        err_addr_d = addr_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      data_l_q     <= '0;
      err_addr_q   <= '0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      data_l_q     <= data_l_d;
      err_addr_q   <= err_addr_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      error_q      <= error_d;
    end
  end

  assign dm_ready_o      = (state_q == ST_IDLE);
  assign dm_data_l_o     = data_l_q;
  assign dm_load_done_o  = load_done_q;
  assign dm_store_done_o = store_done_q;
  assign dm_error_o      = error_q;
  assign dm_error_addr_o = err_addr_q;
  assign wb_cyc_o        = cyc_q;
  assign wb_stb_o        = stb_q;
  assign wb_we_o         = we_q;
  assign wb_adr_o        = {addr_q[31:2], 2'b00};
  assign wb_sel_o        = sel_q;
  assign wb_dat_o        = dat_q;

endmodule
